// File: rtl/fifo_axis_buf.sv
// Valid/ready stream FIFO with first-word-fall-through output, occupancy level and watermark flags.
// Optional peak-occupancy tracking is enabled by defining FIFO_AXIS_WATERMARK_EN.
module fifo_axis_buf #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AFULL_LVL  = 12,
    parameter int unsigned AEMPTY_LVL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef FIFO_AXIS_WATERMARK_EN
    input  logic                     hwm_clear,
    output logic [$clog2(DEPTH):0]   hwm,
`endif
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     almost_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_axis_buf: WIDTH must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_axis_buf: DEPTH must be a power of 2 and at least 2");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("fifo_axis_buf: AFULL_LVL must be in 1..DEPTH");
    end
    if (AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_axis_buf: AEMPTY_LVL must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [PW-1:0]    level_nxt;
    logic             full_nxt;
    logic             push;
    logic             pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Next pointer state; flush wins over any push or pop in the same cycle.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PW'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
        end
        level_nxt = wr_ptr_nxt - rd_ptr_nxt;
        full_nxt  = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                    (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
    end

    // Status is precomputed from next-state so in_ready never depends on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            level        <= level_nxt;
            in_ready     <= !full_nxt;
            out_valid    <= (wr_ptr_nxt != rd_ptr_nxt);
            almost_full  <= (level_nxt >= PW'(AFULL_LVL));
            almost_empty <= (level_nxt <= PW'(AEMPTY_LVL));
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= in_data;
    end

    // Head read straight from storage; zero while empty so reset shows a clean bus.
    assign out_data = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

`ifdef FIFO_AXIS_WATERMARK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm <= '0;
        end else if (hwm_clear) begin
            hwm <= level;
        end else if (level_nxt > hwm) begin
            hwm <= level_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_axis_buf.sv
// Self-checking bench for fifo_axis_buf: queue reference model checked every cycle,
// directed test-plan phases with literal expectations, then randomized traffic.
module tb_fifo_axis_buf;

    localparam int unsigned W  = 64;
    localparam int unsigned D  = 16;
    localparam int unsigned LW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [LW-1:0] level;
    logic          almost_full;
    logic          almost_empty;
`ifdef FIFO_AXIS_WATERMARK_EN
    logic          hwm_clear;
    logic [LW-1:0] hwm;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_axis_buf #(.WIDTH(W), .DEPTH(D), .AFULL_LVL(12), .AEMPTY_LVL(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef FIFO_AXIS_WATERMARK_EN
        .hwm_clear    (hwm_clear),
        .hwm          (hwm),
`endif
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue plus the registered acceptance flag.
    logic [W-1:0] q[$];
    bit           m_rdy;
    int           m_hwm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_rdy = 1'b0;
            m_hwm = 0;
        end else begin
            int old_size;
            old_size = q.size();
            if (flush) begin
                q.delete();
            end else begin
                bit do_push;
                bit do_pop;
                do_push = in_valid && m_rdy;
                do_pop  = (q.size() != 0) && out_ready;
                if (do_pop)  void'(q.pop_front());
                if (do_push) q.push_back(in_data);
            end
            m_rdy = (q.size() != D);
`ifdef FIFO_AXIS_WATERMARK_EN
            if (hwm_clear) m_hwm = old_size;
            else if (q.size() > m_hwm) m_hwm = q.size();
`else
            if (q.size() > m_hwm) m_hwm = old_size;
`endif
        end
    end

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("cyc_out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("cyc_level", 64'(level), 64'(q.size()));
        chk("cyc_in_ready", 64'(in_ready), 64'(m_rdy));
        chk("cyc_almost_full", 64'(almost_full), 64'(q.size() >= 12));
        chk("cyc_almost_empty", 64'(almost_empty), 64'(q.size() <= 2));
        if (q.size() != 0) chk("cyc_out_data", out_data, q[0]);
`ifdef FIFO_AXIS_WATERMARK_EN
        chk("cyc_hwm", 64'(hwm), 64'(m_hwm));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic fill(input int n, input logic [63:0] base);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 64'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain_all();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < D + 1; i++) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
`ifdef FIFO_AXIS_WATERMARK_EN
        hwm_clear = 1'b0;
`endif
        idle();
        repeat (2) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_almost_empty", 64'(almost_empty), 64'd1);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready_after", 64'(in_ready), 64'd1);

        // Fill to full with out_ready low, then drain in order.
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            tick();
            chk("fill_level", 64'(level), 64'(i));
            chk("fill_almost_full", 64'(almost_full), 64'(i >= 12));
        end
        in_valid = 1'b0;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_level", 64'(level), 64'd16);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("drain_data", out_data, 64'(i));
            tick();
            chk("drain_almost_empty", 64'(almost_empty), 64'(16 - i <= 2));
        end
        out_ready = 1'b0;
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        // Single-beat latency.
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        tick();
        in_valid = 1'b0;
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_data", out_data, 64'hDEAD);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("lat_gone", 64'(out_valid), 64'd0);

        // Streaming at level 8 across pointer wrap.
        fill(8, 64'd100);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = 64'd108 + 64'(i);
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_data", out_data, 64'd100 + 64'(i));
            tick();
            chk("stream_level", 64'(level), 64'd8);
        end
        drain_all();

        // Full with simultaneous pop: pop happens, push is refused.
        fill(16, 64'd200);
        in_valid  = 1'b1;
        in_data   = 64'd999;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("fullpop_level", 64'(level), 64'd15);
        chk("fullpop_in_ready", 64'(in_ready), 64'd1);
        chk("fullpop_head", out_data, 64'd201);
        drain_all();

        // Flush with a coincident push.
        fill(5, 64'd300);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'h55;
        tick();
        idle();
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_almost_empty", 64'(almost_empty), 64'd1);
        tick();
        chk("flush_dropped", 64'(level), 64'd0);

        // Flush from full restores in_ready.
        fill(16, 64'd400);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_full_in_ready", 64'(in_ready), 64'd1);

        // Randomized traffic with an asynchronous reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 99) < 60);
            out_ready = 1'($urandom_range(0, 99) < 50);
            flush     = 1'($urandom_range(0, 99) < 2);
            in_data   = {$urandom, $urandom};
            if (c == 1500) begin
                #1;
                rst_n = 1'b0;
                #1;
                chk("async_rst_out_valid", 64'(out_valid), 64'd0);
                chk("async_rst_level", 64'(level), 64'd0);
                chk("async_rst_in_ready", 64'(in_ready), 64'd0);
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        idle();
        drain_all();

`ifdef FIFO_AXIS_WATERMARK_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        fill(10, 64'd500);
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        chk("hwm_peak", 64'(hwm), 64'd10);
        hwm_clear = 1'b1;
        tick();
        hwm_clear = 1'b0;
        chk("hwm_clear", 64'(hwm), 64'd4);
        drain_all();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
